branch_unit: RTL
================

# branch_unit

Branch resolution and direction-prediction unit for the pipelined RV32I core; the consumer of the branch comparator's flags. In EX it selects the comparator's signedness, turns the equal/less-than flags into a taken decision per funct3, checks the fetch-time prediction, and issues a registered redirect/flush on mispredict. It owns a table of 2-bit saturating counters read by IF and trained by EX, plus branch/mispredict performance counters.

## Interface
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, >= 2; IDX = log2(BHT_ENTRIES)
- INIT_STATE, 2'b01, counter value loaded into every entry on reset
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_if_pc  in  32  fetch PC for prediction lookup
- o_if_pred_taken  out  1  predicted direction for i_if_pc (combinational)
- i_ex_valid  in  1  EX stage holds a real instruction
- i_ex_is_br  in  1  EX instruction is a conditional branch (opcode 1100011)
- i_ex_funct3  in  3  branch funct3
- i_ex_pc  in  32  branch PC
- i_ex_target  in  32  branch target (pc + B-imm), computed upstream
- i_ex_pred_taken  in  1  prediction carried down the pipe with this branch
- o_br_un  out  1  to comparator: 1 = unsigned compare (combinational)
- i_br_eq  in  1  comparator rs1 == rs2
- i_br_lt  in  1  comparator rs1 < rs2 (signedness per o_br_un)
- o_ex_taken  out  1  resolved direction (combinational)
- o_redirect  out  1  one-cycle pulse: fetch must load o_redirect_pc
- o_redirect_pc  out  32  correct next PC
- o_flush  out  1  equals o_redirect; kill IF/ID contents
- o_br_count  out  32  resolved branches
- o_mispred_count  out  32  mispredicted branches

## Operation
- Resolve qualifier: res = i_ex_valid & i_ex_is_br & ~o_redirect & legal; legal = funct3 not in {010, 011}.
- o_br_un = funct3[1] (BLTU 110, BGEU 111); 0 otherwise, including when no branch is present.
- Direction: 000 BEQ eq; 001 BNE ~eq; 100/110 BLT/BLTU lt; 101/111 BGE/BGEU ~lt. o_ex_taken = res & direction.
- Illegal funct3 (010/011): not taken, no redirect, no table update, no count change.
- Mispredict = res & (o_ex_taken != i_ex_pred_taken). Next cycle: o_redirect = o_flush = 1, o_redirect_pc = taken ? i_ex_target : i_ex_pc + 4 (32-bit modulo add; 0xFFFF_FFFC + 4 = 0).
- Correct prediction: no redirect.
- Squash: while o_redirect = 1 the instruction in EX is wrong-path; it is not resolved, trained, or counted, and cannot raise a new redirect. Back-to-back redirects are therefore impossible.
- Table index = pc[IDX+1:2]. Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter[1].
- Training on res: taken -> +1 saturating at 11; not taken -> -1 saturating at 00.
- o_br_count +1 per res; o_mispred_count +1 per mispredict; both wrap 0xFFFF_FFFF -> 0.

## Timing
- o_br_un, o_ex_taken, o_if_pred_taken: combinational, same cycle.
- Redirect: registered; asserted exactly one cycle after the resolving EX cycle, for exactly one cycle.
- Table write at the rising edge ending the resolving cycle. An IF read of the same index in that cycle returns the old value; the new value is visible from the next cycle.
- Counters update on the same edge as the table.
- Reset (i_rst = 1 at an edge): every entry = INIT_STATE; o_redirect = o_flush = 0; o_redirect_pc = 0; both counters = 0. A redirect pending from the cycle before reset is dropped. Inputs are ignored while i_rst = 1.

## Test plan
- Reset then BEQ at pc 0x100, eq=1, pred=0, target 0x140 -> o_br_un = 0, o_ex_taken = 1; next cycle o_redirect = 1, o_redirect_pc = 0x140; entry 0x100 becomes 10; o_mispred_count = 1.
- BGEU with lt=1, pred=1, pc 0x200 -> o_br_un = 1, not taken; o_redirect_pc = 0x204; entry 0x200 goes 01 -> 00; a second identical branch leaves it at 00 (saturation).
- Train pc 0x300 taken four times -> counter 01 -> 10 -> 11 -> 11; o_if_pred_taken = 1 at 0x300 from the cycle after the first update; same-cycle read during that update returns 0.
- Mispredict followed by a valid branch in EX during the redirect cycle -> the second branch is ignored: no redirect, no training, o_br_count unchanged.
- funct3 = 010 with i_ex_is_br = 1 -> o_ex_taken = 0, no redirect, counters unchanged; pc 0xFFFF_FFFC mispredicted not-taken -> o_redirect_pc = 0x0000_0000.
- Assert i_rst in the cycle a redirect would appear -> o_redirect = 0; all entries read INIT_STATE; counters = 0.

Source files
------------

// File: rtl/branch_unit.sv
// Resolves conditional branches in EX, trains a 2-bit BHT read by IF, and redirects fetch on mispredict.
// Latency: direction and prediction are combinational; redirect/flush is registered, one cycle after resolve.
// Backpressure: none; any branch in EX during a redirect cycle is wrong-path and is squashed.
module branch_unit #(
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] INIT_STATE  = 2'b01
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    output logic        o_if_pred_taken,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    output logic        o_br_un,
    input  logic        i_br_eq,
    input  logic        i_br_lt,
    output logic        o_ex_taken,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [1:0]     bht [BHT_ENTRIES];
    logic [IDX-1:0] if_idx;
    logic [IDX-1:0] ex_idx;
    logic           legal;
    logic           direction;
    logic           res;
    logic           mispred;
    logic           unused_pc_bits;

    // Word-aligned PCs: drop the byte offset, keep IDX index bits.
    assign if_idx = i_if_pc[IDX+1:2];
    assign ex_idx = i_ex_pc[IDX+1:2];
    assign unused_pc_bits = ^{i_if_pc[31:IDX+2], i_if_pc[1:0]};

    // Prediction is the MSB of the counter; read sees the pre-update value.
    assign o_if_pred_taken = bht[if_idx][1];

    // Decode funct3 into a direction from the comparator flags.
    always_comb begin
        legal     = 1'b1;
        direction = 1'b0;
        case (i_ex_funct3)
            3'b000:  direction = i_br_eq;
            3'b001:  direction = ~i_br_eq;
            3'b100,
            3'b110:  direction = i_br_lt;
            3'b101,
            3'b111:  direction = ~i_br_lt;
            default: legal     = 1'b0;
        endcase
    end

    // Unsigned compare only for BLTU/BGEU of a branch actually in EX.
    assign o_br_un    = i_ex_valid & i_ex_is_br & i_ex_funct3[2] & i_ex_funct3[1];
    // The redirect cycle's EX instruction is wrong-path and never resolves.
    assign res        = i_ex_valid & i_ex_is_br & ~o_redirect & legal;
    assign o_ex_taken = res & direction;
    assign mispred    = res & (o_ex_taken != i_ex_pred_taken);
    assign o_flush    = o_redirect;

    // Saturating counter training on every resolved branch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= INIT_STATE;
            end
        end else if (res) begin
            if (direction && (bht[ex_idx] != 2'b11)) begin
                bht[ex_idx] <= bht[ex_idx] + 2'd1;
            end else if (!direction && (bht[ex_idx] != 2'b00)) begin
                bht[ex_idx] <= bht[ex_idx] - 2'd1;
            end
        end
    end

    // One-cycle redirect pulse plus performance counters; reset drops a pending redirect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_redirect      <= 1'b0;
            o_redirect_pc   <= 32'd0;
            o_br_count      <= 32'd0;
            o_mispred_count <= 32'd0;
        end else begin
            o_redirect <= mispred;
            if (mispred) begin
                o_redirect_pc   <= direction ? i_ex_target : (i_ex_pc + 32'd4);
                o_mispred_count <= o_mispred_count + 32'd1;
            end
            if (res) begin
                o_br_count <= o_br_count + 32'd1;
            end
        end
    end

endmodule
